// File: rtl/irq_cond.sv
// irq_cond
// Conditions eight raw asynchronous interrupt sources into clean requests
// for a downstream priority resolver. Each source is synchronized, optionally
// inverted, and then either passed through (level mode) or captured into a
// write-1-to-clear pending latch on its active edge (edge mode). Control and
// status registers are reached over a small Wishbone B2 slave port.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   irq_in     raw interrupt sources, bit i = source i
//   ir         conditioned requests, bit i drives ir<i>
//   wb_cyc/wb_std/wb_sel  bus access qualifiers (all three must be high)
//   wb_we      1 = write, 0 = read
//   wb_addr    0 MODE, 1 POL, 2 PEND (write-1-to-clear), 3 RAW (read-only)
//   wb_din     write data
//   wb_dout    registered read data
//   wb_ack     registered single-cycle acknowledge
//
// Build option
//   IRQ_COND_GLITCH_FILTER_EN  when defined, each synchronized source only
//   changes after three consecutive identical samples; level and edge
//   latencies each grow by two cycles and RAW reads the filtered value.

module irq_cond (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq_in,
    output logic [7:0] ir,
    input  logic       wb_cyc,
    input  logic       wb_std,
    input  logic       wb_sel,
    input  logic       wb_we,
    input  logic [1:0] wb_addr,
    input  logic [7:0] wb_din,
    output logic [7:0] wb_dout,
    output logic       wb_ack
);

    // Cycles after reset during which edge capture stays disabled, long
    // enough for a source held high through reset to reach previous-a.
`ifdef IRQ_COND_GLITCH_FILTER_EN
    localparam logic [2:0] WARM_MAX = 3'd5;
`else
    localparam logic [2:0] WARM_MAX = 3'd3;
`endif

    logic [7:0] sync1_q, sync1_d;
    logic [7:0] sync2_q, sync2_d;
    logic [7:0] prev_a_q, prev_a_d;
    logic [7:0] mode_q, mode_d;
    logic [7:0] pol_q, pol_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] dout_q, dout_d;
    logic       ack_q, ack_d;
    logic [2:0] warm_q, warm_d;
`ifdef IRQ_COND_GLITCH_FILTER_EN
    logic [7:0] hist_q, hist_d;
    logic [7:0] filt_q, filt_d;
    logic [7:0] same;
`endif

    logic [7:0] s_val;
    logic [7:0] active;
    logic [7:0] set_bits;
    logic [7:0] clr_bits;
    logic       access;
    logic       take;
    logic       wr_en;
    logic       rd_en;
    logic       edge_en;

`ifdef IRQ_COND_GLITCH_FILTER_EN
    assign s_val = filt_q;
`else
    assign s_val = sync2_q;
`endif

    assign active  = s_val ^ pol_q;
    assign ir      = (mode_q & pend_q) | (~mode_q & active);
    assign wb_dout = dout_q;
    assign wb_ack  = ack_q;

    always_comb begin
        sync1_d  = irq_in;
        sync2_d  = sync1_q;
        mode_d   = mode_q;
        pol_d    = pol_q;
        dout_d   = dout_q;
        clr_bits = 8'h00;
`ifdef IRQ_COND_GLITCH_FILTER_EN
        // Three samples of the synchronizer output: the one about to be
        // captured (sync1_q), the current one and the previous one.
        hist_d = sync2_q;
        same   = ~(sync1_q ^ sync2_q) & ~(sync2_q ^ hist_q);
        filt_d = (same & sync1_q) | (~same & filt_q);
`endif

        // Ack drops for one cycle after each beat so a held access yields
        // one transfer per ack.
        access = wb_cyc & wb_std & wb_sel;
        take   = access & ~ack_q;
        wr_en  = take & wb_we;
        rd_en  = take & ~wb_we;
        ack_d  = take;

        if (wr_en) begin
            case (wb_addr)
                2'd0:    mode_d   = wb_din;
                2'd1:    pol_d    = wb_din;
                2'd2:    clr_bits = wb_din;
                default: ;
            endcase
        end

        if (rd_en) begin
            case (wb_addr)
                2'd0:    dout_d = mode_q;
                2'd1:    dout_d = pol_q;
                2'd2:    dout_d = pend_q;
                default: dout_d = s_val;
            endcase
        end

        edge_en = (warm_q == WARM_MAX);
        warm_d  = edge_en ? warm_q : warm_q + 3'd1;

        // Set has priority over a simultaneous clear; level-mode bits
        // (including ones switched to level this cycle) are forced low.
        set_bits = active & ~prev_a_q & mode_q & {8{edge_en}};
        pend_d   = ((pend_q & ~clr_bits) | set_bits) & mode_d;

        // Previous-a uses the new polarity so a POL write alone never
        // looks like an edge.
        prev_a_d = s_val ^ pol_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 8'h00;
            sync2_q  <= 8'h00;
            prev_a_q <= 8'h00;
            mode_q   <= 8'h00;
            pol_q    <= 8'h00;
            pend_q   <= 8'h00;
            dout_q   <= 8'h00;
            ack_q    <= 1'b0;
            warm_q   <= 3'd0;
`ifdef IRQ_COND_GLITCH_FILTER_EN
            hist_q   <= 8'h00;
            filt_q   <= 8'h00;
`endif
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_a_q <= prev_a_d;
            mode_q   <= mode_d;
            pol_q    <= pol_d;
            pend_q   <= pend_d;
            dout_q   <= dout_d;
            ack_q    <= ack_d;
            warm_q   <= warm_d;
`ifdef IRQ_COND_GLITCH_FILTER_EN
            hist_q   <= hist_d;
            filt_q   <= filt_d;
`endif
        end
    end

endmodule
